// File: rtl/aximm_avmm_test_sequencer.sv
// AVMM master that drives the AXI-MM GPIO link self-test: programs delays, waits
// for link-up, runs the M2S then S2M write/read tests, and reports the outcome.
`timescale 1ns/1ps
module aximm_avmm_test_sequencer #(
  parameter logic [31:0] DLY_X      = 32'h0000_000C,
  parameter logic [31:0] DLY_Y      = 32'h0000_0020,
  parameter logic [31:0] DLY_Z      = 32'h0000_1770,
  parameter logic [31:0] TEST_ADDR  = 32'h1000_0000,
  parameter logic [31:0] TEST_CFG   = 32'h0004_1804,
  parameter int unsigned POLL_GAP   = 20,
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic        avmm_clk,
  input  logic        avmm_rst,
  input  logic        i_start,
  output logic [31:0] o_master_address,
  output logic        o_master_write,
  output logic        o_master_read,
  output logic [31:0] o_master_writedata,
  input  logic        i_master_waitrequest,
  input  logic        i_master_readdatavalid,
  input  logic [31:0] i_master_readdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_pass,
  output logic [2:0]  o_err
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CFG_DLY   = 4'd1;
  localparam logic [3:0] S_POLL_LINK = 4'd2;
  localparam logic [3:0] S_KICK_WR   = 4'd3;
  localparam logic [3:0] S_POLL_WR   = 4'd4;
  localparam logic [3:0] S_KICK_RD   = 4'd5;
  localparam logic [3:0] S_POLL_RD   = 4'd6;
  localparam logic [3:0] S_CHECK     = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  localparam int unsigned GAP_W = (POLL_GAP   < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam int unsigned PCW   = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);

  logic [3:0]       state;
  logic [1:0]       step;
  logic             phase;
  logic             rd_pend;
  logic [GAP_W-1:0] gap_cnt;
  logic [PCW-1:0]   poll_cnt;

  logic [31:0] reg_base;
  logic [31:0] op_addr;
  logic [31:0] op_data;
  logic        op_rd;
  logic        op_go;
  logic        gap_done;
  logic        bus_idle;
  logic        wr_acc;
  logic        rd_acc;
  logic        rd_done;
  logic        poll_hit;
  logic        poll_last;
  logic [3:0]  poll_next;
  logic [2:0]  to_err;
  logic [2:0]  chk_err;
  logic        rsp_fin;
  logic [2:0]  rsp_err;
  logic        unused_rdata;

  assign unused_rdata = ^i_master_readdata[31:6];

  assign reg_base  = phase ? 32'h5000_1020 : 32'h5000_1000;
  assign gap_done  = (gap_cnt == GAP_W'(POLL_GAP));
  assign bus_idle  = !o_master_write && !o_master_read && !rd_pend;
  assign wr_acc    = o_master_write && !i_master_waitrequest;
  assign rd_acc    = o_master_read && !i_master_waitrequest;
  assign rd_done   = rd_pend && i_master_readdatavalid;
  assign poll_last = (poll_cnt >= PCW'(POLL_LIMIT - 1));

  // Next bus operation for the current state/step
  always_comb begin
    op_addr = '0;
    op_data = '0;
    op_rd   = 1'b0;
    op_go   = 1'b0;
    case (state)
      S_CFG_DLY: begin
        op_go = 1'b1;
        case (step)
          2'd0:    begin op_addr = 32'h5000_2000; op_data = DLY_X; end
          2'd1:    begin op_addr = 32'h5000_2004; op_data = DLY_Y; end
          default: begin op_addr = 32'h5000_2008; op_data = DLY_Z; end
        endcase
      end
      S_KICK_WR: begin
        op_go   = 1'b1;
        op_addr = (step == 2'd0) ? reg_base + 32'h4 : reg_base;
        op_data = (step == 2'd0) ? TEST_ADDR : TEST_CFG;
      end
      S_KICK_RD: begin
        op_go   = 1'b1;
        op_addr = (step == 2'd0) ? reg_base + 32'h4 : reg_base + 32'h10;
        op_data = (step == 2'd0) ? TEST_ADDR : TEST_CFG;
      end
      S_POLL_LINK: begin
        op_rd   = 1'b1;
        op_go   = gap_done;
        op_addr = 32'h5000_100C;
      end
      S_POLL_WR, S_POLL_RD: begin
        op_rd   = 1'b1;
        op_go   = gap_done;
        op_addr = reg_base + 32'h8;
      end
      S_CHECK: begin
        op_rd   = 1'b1;
        op_go   = 1'b1;
        op_addr = reg_base + 32'h8;
      end
      default: ;
    endcase
  end

  // Read-response evaluation for poll and check stages
  always_comb begin
    poll_hit  = 1'b0;
    poll_next = S_IDLE;
    to_err    = 3'd0;
    case (state)
      S_POLL_LINK: begin poll_hit = (i_master_readdata[3:0] == 4'hF); poll_next = S_KICK_WR; to_err = 3'd1; end
      S_POLL_WR:   begin poll_hit = i_master_readdata[4];            poll_next = S_KICK_RD; to_err = 3'd2; end
      S_POLL_RD:   begin poll_hit = i_master_readdata[5];            poll_next = S_CHECK;   to_err = 3'd3; end
      default: ;
    endcase
    if (!i_master_readdata[3] || !i_master_readdata[2]) chk_err = 3'd4;
    else if (i_master_readdata[3:0] != 4'hF)             chk_err = 3'd5;
    else                                                 chk_err = 3'd0;
    if (state == S_CHECK) begin
      rsp_fin = (chk_err != 3'd0) || phase;
      rsp_err = chk_err;
    end else begin
      rsp_fin = !poll_hit && poll_last;
      rsp_err = to_err;
    end
  end

  always_ff @(posedge avmm_clk or posedge avmm_rst) begin
    if (avmm_rst) begin
      state              <= S_IDLE;
      step               <= '0;
      phase              <= 1'b0;
      rd_pend            <= 1'b0;
      gap_cnt            <= '0;
      poll_cnt           <= '0;
      o_master_address   <= '0;
      o_master_write     <= 1'b0;
      o_master_read      <= 1'b0;
      o_master_writedata <= '0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_pass             <= '0;
      o_err              <= '0;
    end else begin
      o_done <= 1'b0;
      if (state == S_IDLE) begin
        if (i_start) begin
          state    <= S_CFG_DLY;
          step     <= '0;
          phase    <= 1'b0;
          gap_cnt  <= '0;
          poll_cnt <= '0;
          o_busy   <= 1'b1;
          o_pass   <= '0;
          o_err    <= '0;
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end else if (wr_acc) begin
        o_master_write <= 1'b0;
        if ((state == S_CFG_DLY && step == 2'd2) || (state != S_CFG_DLY && step == 2'd1)) begin
          state    <= (state == S_CFG_DLY) ? S_POLL_LINK :
                      (state == S_KICK_WR) ? S_POLL_WR : S_POLL_RD;
          step     <= '0;
          gap_cnt  <= '0;
          poll_cnt <= '0;
        end else begin
          step <= step + 2'd1;
        end
      end else if (rd_acc) begin
        o_master_read <= 1'b0;
        rd_pend       <= 1'b1;
      end else if (rd_done) begin
        rd_pend <= 1'b0;
        gap_cnt <= '0;
        if (state == S_CHECK && chk_err == 3'd0) o_pass[phase] <= 1'b1;
        if (rsp_fin) begin
          state  <= S_DONE;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          o_err  <= rsp_err;
        end else if (state == S_CHECK) begin
          phase    <= 1'b1;
          state    <= S_KICK_WR;
          step     <= '0;
          poll_cnt <= '0;
        end else if (poll_hit) begin
          state    <= poll_next;
          step     <= '0;
          poll_cnt <= '0;
        end else begin
          poll_cnt <= poll_cnt + 1'b1;
        end
      end else if (bus_idle) begin
        if (op_go) begin
          o_master_address   <= op_addr;
          o_master_writedata <= op_rd ? '0 : op_data;
          o_master_write     <= !op_rd;
          o_master_read      <= op_rd;
        end else if (gap_cnt < GAP_W'(POLL_GAP)) begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aximm_avmm_test_sequencer.sv
// Randomized bench for aximm_avmm_test_sequencer: a scripted AVMM slave records every
// accepted operation and results are compared against a rule-level sequence model.
`timescale 1ns/1ps
module tb_aximm_avmm_test_sequencer;

  localparam int unsigned LIMIT = 8;
  localparam int unsigned GAP   = 6;
  localparam logic [31:0] DX = 32'h0000_000C;
  localparam logic [31:0] DY = 32'h0000_0020;
  localparam logic [31:0] DZ = 32'h0000_1770;
  localparam logic [31:0] TA = 32'h1000_0000;
  localparam logic [31:0] TC = 32'h0004_1804;

  logic        avmm_clk = 1'b0;
  logic        avmm_rst = 1'b0;
  logic        i_start  = 1'b0;
  logic [31:0] o_master_address;
  logic        o_master_write;
  logic        o_master_read;
  logic [31:0] o_master_writedata;
  logic        i_master_waitrequest   = 1'b0;
  logic        i_master_readdatavalid = 1'b0;
  logic [31:0] i_master_readdata      = '0;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_pass;
  logic [2:0]  o_err;

  always #5 avmm_clk = ~avmm_clk;

  aximm_avmm_test_sequencer #(
    .DLY_X(DX), .DLY_Y(DY), .DLY_Z(DZ), .TEST_ADDR(TA), .TEST_CFG(TC),
    .POLL_GAP(GAP), .POLL_LIMIT(LIMIT)
  ) dut (
    .avmm_clk(avmm_clk), .avmm_rst(avmm_rst), .i_start(i_start),
    .o_master_address(o_master_address), .o_master_write(o_master_write),
    .o_master_read(o_master_read), .o_master_writedata(o_master_writedata),
    .i_master_waitrequest(i_master_waitrequest),
    .i_master_readdatavalid(i_master_readdatavalid),
    .i_master_readdata(i_master_readdata),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err(o_err)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } op_t;

  op_t exp_q[$];
  op_t obs_q[$];
  logic [1:0] exp_pass;
  logic [2:0] exp_err;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave configuration and state
  int unsigned cfg_wait, cfg_link, cfg_wr, cfg_rd;
  logic [3:0]  cfg_nib [2];
  bit          cfg_spur;
  bit          in_op, pend, wr_act, rd_act, s2m_seen;
  int unsigned stall_left, lat, link_cnt, sts_cnt, cyc, done_cnt;
  logic [31:0] pend_data;
  logic [1:0]  done_pass;
  logic [2:0]  done_err;
  int unsigned link_cyc[$];
  logic        prev_wr, prev_rd, prev_wait;
  logic [31:0] prev_addr, prev_data;

  task automatic slave_reset();
    in_op = 0; pend = 0; wr_act = 0; rd_act = 0; s2m_seen = 0;
    stall_left = 0; lat = 0; link_cnt = 0; sts_cnt = 0; done_cnt = 0;
    done_pass = '0; done_err = '0;
    link_cyc.delete(); obs_q.delete();
    prev_wr = 0; prev_rd = 0; prev_wait = 0;
  endtask

  // Slave: decides inputs 1ns after each rising edge, from the outputs the DUT now presents
  initial begin
    logic [31:0] d;
    cyc = 0;
    forever begin
      @(posedge avmm_clk); #1;
      cyc++;
      if (avmm_rst) begin
        i_master_waitrequest = 0; i_master_readdatavalid = 0;
        in_op = 0; pend = 0; prev_wr = 0; prev_rd = 0; prev_wait = 0;
        continue;
      end
      if ((prev_wr || prev_rd) && prev_wait) begin
        check32("hold_req",  {30'b0, o_master_write, o_master_read}, {30'b0, prev_wr, prev_rd});
        check32("hold_addr", o_master_address, prev_addr);
        if (prev_wr) check32("hold_data", o_master_writedata, prev_data);
      end
      if (o_master_write || o_master_read) begin
        check32("rw_excl", 32'(o_master_write & o_master_read), 32'd0);
        if (o_master_address >= 32'h5000_1020 && o_master_address <= 32'h5000_103F) s2m_seen = 1;
      end
      if (o_done) begin
        done_cnt++;
        done_pass = o_pass;
        done_err  = o_err;
        check32("busy_at_done", 32'(o_busy), 32'd0);
      end
      i_master_readdatavalid = 0;
      if (pend) begin
        if (lat > 1) lat--;
        else begin
          i_master_readdatavalid = 1;
          i_master_readdata = pend_data;
          pend = 0;
        end
      end
      if (o_master_write || o_master_read) begin
        if (!in_op) begin
          in_op = 1;
          stall_left = cfg_wait;
          if (o_master_read && o_master_address == 32'h5000_100C) link_cyc.push_back(cyc);
        end
        if (stall_left > 0) begin
          i_master_waitrequest = 1;
          stall_left--;
        end else begin
          i_master_waitrequest = 0;
          in_op = 0;
          if (o_master_write) begin
            obs_q.push_back('{1'b1, o_master_address, o_master_writedata});
            if (o_master_address == 32'h5000_1000 || o_master_address == 32'h5000_1020) begin
              wr_act = 1; rd_act = 0; sts_cnt = 0;
            end
            if (o_master_address == 32'h5000_1010 || o_master_address == 32'h5000_1030) begin
              rd_act = 1; sts_cnt = 0;
            end
          end else begin
            obs_q.push_back('{1'b0, o_master_address, 32'h0});
            d = $urandom();
            if (o_master_address == 32'h5000_100C) begin
              link_cnt++;
              d[3:0] = (link_cnt >= cfg_link) ? 4'hF : 4'h7;
            end else begin
              sts_cnt++;
              d[3:0] = cfg_nib[o_master_address[5]];
              d[4]   = wr_act && (sts_cnt >= cfg_wr);
              d[5]   = rd_act && (sts_cnt >= cfg_rd);
            end
            pend = 1;
            pend_data = d;
            lat = $urandom_range(1, 3);
          end
        end
      end else begin
        i_master_waitrequest = 0;
        if (cfg_spur && !pend && !i_master_readdatavalid && $urandom_range(0, 3) == 0) begin
          i_master_readdatavalid = 1;
          i_master_readdata = 32'h0;
        end
      end
      prev_wr = o_master_write; prev_rd = o_master_read; prev_wait = i_master_waitrequest;
      prev_addr = o_master_address; prev_data = o_master_writedata;
    end
  end

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Expected bus transcript and result, straight from the sequence rules
  task automatic build_expected(input int unsigned lk, input int unsigned wr, input int unsigned rd,
                                input logic [3:0] n0, input logic [3:0] n1);
    logic [31:0] b;
    logic [3:0]  s;
    exp_q.delete(); exp_pass = '0; exp_err = '0;
    exp_q.push_back('{1'b1, 32'h5000_2000, DX});
    exp_q.push_back('{1'b1, 32'h5000_2004, DY});
    exp_q.push_back('{1'b1, 32'h5000_2008, DZ});
    repeat (umin(lk, LIMIT)) exp_q.push_back('{1'b0, 32'h5000_100C, 32'h0});
    if (lk > LIMIT) begin exp_err = 3'd1; return; end
    for (int ph = 0; ph < 2; ph++) begin
      b = (ph == 1) ? 32'h5000_1020 : 32'h5000_1000;
      exp_q.push_back('{1'b1, b + 32'h4, TA});
      exp_q.push_back('{1'b1, b, TC});
      repeat (umin(wr, LIMIT)) exp_q.push_back('{1'b0, b + 32'h8, 32'h0});
      if (wr > LIMIT) begin exp_err = 3'd2; return; end
      exp_q.push_back('{1'b1, b + 32'h4, TA});
      exp_q.push_back('{1'b1, b + 32'h10, TC});
      repeat (umin(rd, LIMIT)) exp_q.push_back('{1'b0, b + 32'h8, 32'h0});
      if (rd > LIMIT) begin exp_err = 3'd3; return; end
      exp_q.push_back('{1'b0, b + 32'h8, 32'h0});
      s = (ph == 1) ? n1 : n0;
      if (s[3] == 1'b0 || s[2] == 1'b0) begin exp_err = 3'd4; return; end
      if (s != 4'hF) begin exp_err = 3'd5; return; end
      exp_pass[ph] = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check32({tag, "_addr"},  o_master_address, 32'h0);
    check32({tag, "_wdata"}, o_master_writedata, 32'h0);
    check32({tag, "_ctl"},   {28'b0, o_master_write, o_master_read, o_busy, o_done}, 32'h0);
    check32({tag, "_pass"},  32'(o_pass), 32'h0);
    check32({tag, "_err"},   32'(o_err), 32'h0);
  endtask

  task automatic run_scenario(input string name, input int unsigned w, input int unsigned lk,
                              input int unsigned wr, input int unsigned rd,
                              input logic [3:0] n0, input logic [3:0] n1, input bit spur);
    int unsigned k, n, dgap;
    bit exp_s2m;
    cfg_wait = w; cfg_link = lk; cfg_wr = wr; cfg_rd = rd;
    cfg_nib[0] = n0; cfg_nib[1] = n1; cfg_spur = spur;
    slave_reset();
    build_expected(lk, wr, rd, n0, n1);
    @(posedge avmm_clk); #2 i_start = 1;
    @(posedge avmm_clk); #2 i_start = 0;
    check32({name, " busy_after_start"}, 32'(o_busy), 32'd1);
    k = 0;
    while (done_cnt == 0 && k < 20000) begin
      @(posedge avmm_clk); #2;
      k++;
      i_start = spur && (done_cnt == 0) && ((k % 37) == 5);
    end
    if (spur) begin
      i_start = 1;
      @(posedge avmm_clk); #2 i_start = 0;
    end
    repeat (3 * GAP + 20) @(posedge avmm_clk);
    #2;
    check32({name, " done_count"}, done_cnt, 32'd1);
    check32({name, " busy_end"}, 32'(o_busy), 32'd0);
    check32({name, " pass"}, 32'(done_pass), 32'(exp_pass));
    check32({name, " err"},  32'(done_err),  32'(exp_err));
    check32({name, " n_ops"}, obs_q.size(), exp_q.size());
    n = umin(obs_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      check32($sformatf("%s op%0d kind", name, i), 32'(obs_q[i].wr), 32'(exp_q[i].wr));
      check32($sformatf("%s op%0d addr", name, i), obs_q[i].addr, exp_q[i].addr);
      check32($sformatf("%s op%0d data", name, i), obs_q[i].data, exp_q[i].data);
    end
    exp_s2m = 0;
    foreach (exp_q[i]) if (exp_q[i].addr >= 32'h5000_1020 && exp_q[i].addr <= 32'h5000_103F) exp_s2m = 1;
    check32({name, " s2m_driven"}, 32'(s2m_seen), 32'(exp_s2m));
    for (int i = 1; i < link_cyc.size(); i++) begin
      dgap = link_cyc[i] - link_cyc[i-1];
      check32($sformatf("%s link_gap%0d", name, i), 32'(dgap >= GAP + 1), 32'd1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    bit found;
    logic [3:0] a, b;
    cfg_wait = 0; cfg_link = 1; cfg_wr = 1; cfg_rd = 1;
    cfg_nib[0] = 4'hF; cfg_nib[1] = 4'hF; cfg_spur = 0;
    slave_reset();
    #1 avmm_rst = 1;
    @(posedge avmm_clk); #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge avmm_clk);
    #2 avmm_rst = 0;
    repeat (2) @(posedge avmm_clk);
    #2 check_outputs_zero("idle");

    run_scenario("zero_wait",  0, 1, 1, 1, 4'hF, 4'hF, 0);
    run_scenario("wait5",      5, 1, 1, 1, 4'hF, 4'hF, 0);
    run_scenario("link_to",    0, 100, 1, 1, 4'hF, 4'hF, 0);
    run_scenario("m2s_data",   0, 1, 1, 1, 4'hE, 4'hF, 0);
    run_scenario("s2m_align",  0, 1, 1, 1, 4'hF, 4'hB, 0);
    run_scenario("wr_to",      1, 2, 50, 1, 4'hF, 4'hF, 0);
    run_scenario("rd_to",      0, 3, 2, 50, 4'hF, 4'hF, 0);
    run_scenario("last_poll",  0, LIMIT, LIMIT, LIMIT, 4'hF, 4'hF, 0);

    // reset while polling write status, then a fresh start
    cfg_wait = 0; cfg_link = 1; cfg_wr = 50; cfg_rd = 1; cfg_spur = 0;
    slave_reset();
    @(posedge avmm_clk); #2 i_start = 1;
    @(posedge avmm_clk); #2 i_start = 0;
    found = 0;
    for (k = 0; k < 5000 && !found; k++) begin
      @(posedge avmm_clk); #2;
      if (o_master_read && o_master_address == 32'h5000_1008) found = 1;
    end
    check32("abort_reached_poll_wr", 32'(found), 32'd1);
    #1 avmm_rst = 1;
    #1 check_outputs_zero("abort");
    @(posedge avmm_clk); #2 avmm_rst = 0;
    run_scenario("restart",    0, 1, 1, 1, 4'hF, 4'hF, 0);
    run_scenario("spurious",   2, 2, 2, 2, 4'hF, 4'hF, 1);

    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      run_scenario($sformatf("rand%0d", i), $urandom_range(0, 3), $urandom_range(1, 10),
                   $urandom_range(1, 10), $urandom_range(1, 10), a, b, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
